// File: rtl/linia_rle_enc_pkg.sv
// Shared definitions for the linia run-length encoder: FSM states, record width helper
// and the default word width shared with the linia_op delay line.
package linia_rle_enc_pkg;

  localparam int LINIA_DATA_W     = 5;
  localparam int LINIA_CNT_W      = 8;
  localparam int LINIA_FIFO_DEPTH = 4;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } rle_state_e;

  // A record is {value, run length}, value in the upper bits.
  function automatic int rec_w(input int data_w, input int cnt_w);
    return data_w + cnt_w;
  endfunction

endpackage

// File: rtl/linia_rle_enc_if.sv
// Record output stream of the run-length encoder: show-ahead head record with valid/ready.
// The encoder drives it through the master modport; the consumer uses the slave modport.
interface linia_rle_enc_if #(
  parameter int DATA_W = 5,
  parameter int CNT_W  = 8
) ();

  logic [DATA_W-1:0] out_data;
  logic [CNT_W-1:0]  out_len;
  logic              out_valid;
  logic              out_ready;

  modport master (
    output out_data,
    output out_len,
    output out_valid,
    input  out_ready
  );

  modport slave (
    input  out_data,
    input  out_len,
    input  out_valid,
    output out_ready
  );

endinterface

// File: rtl/linia_rle_enc_rec_fifo.sv
// linia_rec_fifo: synchronous show-ahead FIFO with a registered head word.
// Push and pop in the same cycle are both honoured, also when full; a push into a full FIFO without pop is ignored.
module linia_rec_fifo #(
  parameter int WIDTH = 13,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_push_data,
  input  logic             i_pop,
  output logic             o_full,
  output logic             o_empty,
  output logic [WIDTH-1:0] o_head
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_count;
  logic [WIDTH-1:0] r_head;
  logic             r_head_valid;

  logic             w_pop;
  logic             w_full;
  logic             w_push_ok;
  logic [PTR_W-1:0] w_rd_ptr_next;
  logic [PTR_W:0]   w_count_next;
  logic [WIDTH-1:0] w_head_next;

  assign w_pop     = i_pop && r_head_valid;
  assign w_full    = (r_count == (PTR_W+1)'(DEPTH));
  assign w_push_ok = i_push && (!w_full || w_pop);

  assign w_rd_ptr_next = w_pop ? (r_rd_ptr + PTR_W'(1)) : r_rd_ptr;

  always_comb begin
    w_count_next = r_count;
    if (w_push_ok && !w_pop) begin
      w_count_next = r_count + (PTR_W+1)'(1);
    end else if (!w_push_ok && w_pop) begin
      w_count_next = r_count - (PTR_W+1)'(1);
    end
  end

  // The new head bypasses the array when it is the word being written this cycle.
  always_comb begin
    w_head_next = '0;
    if (w_count_next != '0) begin
      if (w_push_ok && (w_rd_ptr_next == r_wr_ptr)) begin
        w_head_next = i_push_data;
      end else begin
        w_head_next = r_mem[w_rd_ptr_next];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push_ok) begin
      r_mem[r_wr_ptr] <= i_push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_head       <= '0;
      r_head_valid <= 1'b0;
    end else begin
      if (w_push_ok) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      r_rd_ptr     <= w_rd_ptr_next;
      r_count      <= w_count_next;
      r_head       <= w_head_next;
      r_head_valid <= (w_count_next != '0);
    end
  end

  assign o_full  = w_full;
  assign o_empty = !r_head_valid;
  assign o_head  = r_head;

endmodule

// File: rtl/linia_rle_enc.sv
// linia_rle_enc: run-length encodes the delayed word stream into {value, length} records drained by valid/ready.
// Optional LINIA_RLE_DROPCNT_EN adds a saturating drop_cnt output counting records lost to a full FIFO.
module linia_rle_enc
  import linia_rle_enc_pkg::*;
#(
  parameter int DATA_W     = LINIA_DATA_W,
  parameter int CNT_W      = LINIA_CNT_W,
  parameter int FIFO_DEPTH = LINIA_FIFO_DEPTH
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] idata,
  input  logic              ivalid,
  input  logic              flush,
  linia_rle_enc_if.master   rec,
  output logic              overflow
`ifdef LINIA_RLE_DROPCNT_EN
  ,
  output logic [CNT_W-1:0]  drop_cnt
`endif
);

  localparam int              REC_W   = rec_w(DATA_W, CNT_W);
  localparam logic [CNT_W-1:0] LEN_MAX = '1;

  rle_state_e        r_state;
  logic [DATA_W-1:0] r_cur;
  logic [CNT_W-1:0]  r_len;
  logic              r_overflow;

  logic              w_push;
  logic [REC_W-1:0]  w_push_rec;
  logic              w_pop;
  logic              w_fifo_full;
  logic              w_fifo_empty;
  logic              w_drop;
  logic [REC_W-1:0]  w_head;

  // Every push carries the open run; a value change, saturation or flush closes it.
  always_comb begin
    w_push     = 1'b0;
    w_push_rec = {r_cur, r_len};
    if (r_state == ST_RUN) begin
      if (flush) begin
        w_push = 1'b1;
      end else if (ivalid && ((idata != r_cur) || (r_len == LEN_MAX))) begin
        w_push = 1'b1;
      end
    end
  end

  assign w_pop  = !w_fifo_empty && rec.out_ready;
  assign w_drop = w_push && w_fifo_full && !w_pop;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_cur      <= '0;
      r_len      <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_drop) begin
        r_overflow <= 1'b1;
      end
      case (r_state)
        ST_IDLE: begin
          if (ivalid) begin
            r_cur   <= idata;
            r_len   <= CNT_W'(1);
            r_state <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (flush) begin
            if (ivalid) begin
              r_cur <= idata;
              r_len <= CNT_W'(1);
            end else begin
              r_len   <= '0;
              r_state <= ST_IDLE;
            end
          end else if (ivalid) begin
            if ((idata != r_cur) || (r_len == LEN_MAX)) begin
              r_cur <= idata;
              r_len <= CNT_W'(1);
            end else begin
              r_len <= r_len + CNT_W'(1);
            end
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef LINIA_RLE_DROPCNT_EN
  logic [CNT_W-1:0] r_drop_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_drop_cnt <= '0;
    end else if (w_drop && (r_drop_cnt != LEN_MAX)) begin
      r_drop_cnt <= r_drop_cnt + CNT_W'(1);
    end
  end

  assign drop_cnt = r_drop_cnt;
`endif

  linia_rec_fifo #(
    .WIDTH (REC_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_push      (w_push),
    .i_push_data (w_push_rec),
    .i_pop       (w_pop),
    .o_full      (w_fifo_full),
    .o_empty     (w_fifo_empty),
    .o_head      (w_head)
  );

  assign rec.out_data  = w_head[REC_W-1 -: DATA_W];
  assign rec.out_len   = w_head[CNT_W-1:0];
  assign rec.out_valid = !w_fifo_empty;
  assign overflow      = r_overflow;

endmodule

// File: tb/tb_linia_rle_enc.sv
// Scoreboard bench for linia_rle_enc: stimulus queues hand-computed records, a negedge monitor checks every accepted record.
module tb_linia_rle_enc;
  import linia_rle_enc_pkg::*;

  localparam int DW    = 5;
  localparam int CW    = 8;
  localparam int DEPTH = 4;

  typedef struct packed {
    logic [DW-1:0] d;
    logic [CW-1:0] l;
  } rec_t;

  logic          clk    = 1'b0;
  logic          rst_n  = 1'b0;
  logic [DW-1:0] idata  = '0;
  logic          ivalid = 1'b0;
  logic          flush  = 1'b0;
  logic          overflow;
`ifdef LINIA_RLE_DROPCNT_EN
  logic [CW-1:0] drop_cnt;
`endif

  linia_rle_enc_if #(.DATA_W(DW), .CNT_W(CW)) rec ();

  linia_rle_enc #(
    .DATA_W     (DW),
    .CNT_W      (CW),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .idata    (idata),
    .ivalid   (ivalid),
    .flush    (flush),
    .rec      (rec),
    .overflow (overflow)
`ifdef LINIA_RLE_DROPCNT_EN
    ,
    .drop_cnt (drop_cnt)
`endif
  );

  always #5 clk = ~clk;

  rec_t exp_q[$];
  rec_t mon_e;
  int   checks   = 0;
  int   failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
    end
  endtask

  // Monitor: every accepted record must match the head of the expected queue.
  always @(negedge clk) begin
    if (rst_n && rec.out_valid && rec.out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_record: got %0h/%0d expected none", rec.out_data, rec.out_len);
      end else begin
        mon_e = exp_q.pop_front();
        $display("REC data=%0h len=%0d (expect %0h/%0d)", rec.out_data, rec.out_len, mon_e.d, mon_e.l);
        check("rec_data", 32'(rec.out_data), 32'(mon_e.d));
        check("rec_len", 32'(rec.out_len), 32'(mon_e.l));
      end
    end
  end

  task automatic expect_rec(input logic [DW-1:0] d, input logic [CW-1:0] l);
    rec_t e;
    e.d = d;
    e.l = l;
    exp_q.push_back(e);
  endtask

  task automatic drive(input logic [DW-1:0] d, input logic v, input logic f);
    idata  = d;
    ivalid = v;
    flush  = f;
    @(posedge clk);
    #1;
    ivalid = 1'b0;
    flush  = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    exp_q.delete();
    rst_n = 1'b1;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    check({name, "_drained"}, 32'(exp_q.size()), 32'd0);
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    check({name, "_empty_after"}, 32'(rec.out_valid), 32'd0);
  endtask

  initial begin
    rec.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(rec.out_valid), 32'd0);
    check("rst_out_data", 32'(rec.out_data), 32'd0);
    check("rst_out_len", 32'(rec.out_len), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
`ifdef LINIA_RLE_DROPCNT_EN
    check("rst_drop_cnt", 32'(drop_cnt), 32'd0);
`endif
    rst_n = 1'b1;

    // 1: two runs closed by a value change and a flush
    expect_rec(5'h1F, 8'd3);
    expect_rec(5'h00, 8'd2);
    repeat (3) drive(5'h1F, 1'b1, 1'b0);
    repeat (2) drive(5'h00, 1'b1, 1'b0);
    drive(5'h00, 1'b0, 1'b1);
    drain("t1");

    // 2: saturation split of a 300-long run
    expect_rec(5'h0A, 8'd255);
    expect_rec(5'h0A, 8'd45);
    repeat (300) drive(5'h0A, 1'b1, 1'b0);
    drive(5'h00, 1'b0, 1'b1);
    drain("t2");

    // 3: overflow with consumer stalled
    do_reset();
    rec.out_ready = 1'b0;
    expect_rec(5'h01, 8'd1);
    expect_rec(5'h02, 8'd1);
    expect_rec(5'h01, 8'd1);
    expect_rec(5'h02, 8'd1);
    for (int i = 0; i < 3; i++) begin
      drive(5'h01, 1'b1, 1'b0);
      drive(5'h02, 1'b1, 1'b0);
    end
    drive(5'h00, 1'b0, 1'b1);
    check("t3_overflow", 32'(overflow), 32'd1);
`ifdef LINIA_RLE_DROPCNT_EN
    check("t3_drop_cnt", 32'(drop_cnt), 32'd2);
`endif
    check("t3_valid_stalled", 32'(rec.out_valid), 32'd1);
    repeat (3) drive(5'h00, 1'b0, 1'b0);
    check("t3_head_data_stable", 32'(rec.out_data), 32'h01);
    check("t3_head_len_stable", 32'(rec.out_len), 32'd1);
    rec.out_ready = 1'b1;
    drain("t3");
    check("t3_overflow_sticky", 32'(overflow), 32'd1);

    // 4: flush and a new sample in the same cycle
    do_reset();
    expect_rec(5'h05, 8'd2);
    expect_rec(5'h07, 8'd1);
    repeat (2) drive(5'h05, 1'b1, 1'b0);
    drive(5'h07, 1'b1, 1'b1);
    drive(5'h00, 1'b0, 1'b0);
    drive(5'h00, 1'b0, 1'b1);
    drain("t4");
    check("t4_overflow", 32'(overflow), 32'd0);

    // 5: reset mid-run discards queued records
    rec.out_ready = 1'b0;
    expect_rec(5'h01, 8'd1);
    expect_rec(5'h02, 8'd1);
    drive(5'h01, 1'b1, 1'b0);
    drive(5'h02, 1'b1, 1'b0);
    drive(5'h03, 1'b1, 1'b0);
    drive(5'h00, 1'b0, 1'b0);
    check("t5_valid_before_rst", 32'(rec.out_valid), 32'd1);
    do_reset();
    check("t5_valid_after_rst", 32'(rec.out_valid), 32'd0);
    check("t5_len_after_rst", 32'(rec.out_len), 32'd0);
    check("t5_overflow_after_rst", 32'(overflow), 32'd0);
    rec.out_ready = 1'b1;
    expect_rec(5'h04, 8'd2);
    repeat (2) drive(5'h04, 1'b1, 1'b0);
    drive(5'h00, 1'b0, 1'b1);
    drain("t5");

    // 6: ivalid gaps are ignored, even with a different idata on them
    expect_rec(5'h03, 8'd3);
    drive(5'h03, 1'b1, 1'b0);
    drive(5'h1F, 1'b0, 1'b0);
    drive(5'h1F, 1'b0, 1'b0);
    drive(5'h03, 1'b1, 1'b0);
    drive(5'h03, 1'b1, 1'b0);
    drive(5'h00, 1'b0, 1'b1);
    drain("t6");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
